dmux_stream: RTL

- Parametrised, registered demultiplexer for the datapath: routes one input word to one of CHANNELS output channels selected by in_sel, or to all channels in broadcast mode.
- Each output channel has its own DEPTH-entry FIFO with a valid/ready handshake, so a stalled consumer does not block traffic to other channels unless that traffic targets it.
- Used between the instruction/data fetch path and per-unit consumers, where the earlier combinational 4-way demux gave no buffering or flow control.

---
 rtl/dmux_stream.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-CHANNELS demultiplexer with a small FIFO per
// output channel. A word goes to one channel (in_sel) or to all channels at
// once (in_bcast). Each channel has its own valid/ready handshake, so a stalled
// consumer only blocks traffic that targets it.

// Per-channel FIFO. The head entry drives out_data directly, so there is
// exactly one cycle from accept to visibility and no combinational bypass.
module dmux_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int LVL_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LVL_W-1:0] level,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [LVL_W-1:0]            count;
  logic                        do_push, do_pop;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == LVL_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;
  // The top already gates push with !full; the local guard keeps the FIFO safe
  // on its own.
  assign do_push   = push & ~full;
  assign do_pop    = out_valid & out_ready;

  // Storage, pointers and occupancy; memory is cleared so out_data reads 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DEPTH    = 2,
  localparam int LVL_W   = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_bcast,
  output logic [CHANNELS-1:0]         out_valid,
  input  logic [CHANNELS-1:0]         out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS*LVL_W-1:0]   out_level,
  output logic                        sel_err
);
  logic [CHANNELS-1:0] full, sel_hit, push;
  logic                in_range, accept;

  assign in_range = ({1'b0, in_sel} < (SEL_W+1)'(CHANNELS));

  // Decode the select and derive in_ready from FIFO fill state only; out_ready
  // never feeds in_ready, so a full FIFO refuses a push even while popping.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) sel_hit[k] = (in_sel == SEL_W'(k));
    if (!reset_n)      in_ready = 1'b0;
    else if (in_bcast) in_ready = ~|full;
    else if (in_range) in_ready = ~|(sel_hit & full);
    else               in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;
  assign push   = {CHANNELS{accept}} & ({CHANNELS{in_bcast}} | sel_hit);

  // One-cycle flag for an accepted unicast word whose channel does not exist.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_err <= 1'b0;
    else          sel_err <= accept & ~in_bcast & ~in_range;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    dmux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[k]),
      .din       (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .level     (out_level[k*LVL_W +: LVL_W]),
      .full      (full[k])
    );
  end
endmodule
